// File: rtl/ps2_note_pkg.sv
// Shared definitions for the PS/2 note decoder.
//   - PS/2 set-2 scancodes for the prefix bytes and every mapped key
//   - byte-FSM state encoding and key-class encoding
//   - key_info_t: the classified form of one scancode byte
//   - held_bit(): slot of a key in the 16-bit held bitmap
package ps2_note_pkg;

    localparam int NUM_NOTES = 12;

    // Prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    // Note keys, in note-index order 0..11
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_J = 8'h3B;

    // Control keys
    localparam logic [7:0] SC_Z = 8'h1A;  // octave down
    localparam logic [7:0] SC_X = 8'h22;  // octave up
    localparam logic [7:0] SC_C = 8'h21;  // ADSR value down
    localparam logic [7:0] SC_V = 8'h2A;  // ADSR value up

    // Envelope-stage selector keys 1..5
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        KC_NONE    = 3'd0,
        KC_NOTE    = 3'd1,
        KC_OCT_DN  = 3'd2,
        KC_OCT_UP  = 3'd3,
        KC_ADSR_DN = 3'd4,
        KC_ADSR_UP = 3'd5,
        KC_SEL     = 3'd6
    } key_class_t;

    typedef struct packed {
        key_class_t cls;
        logic [3:0] idx;  // note 0..11 or selector 0..4
    } key_info_t;

    // Notes occupy bitmap slots 0..11, the four controls slots 12..15.
    function automatic logic [3:0] held_bit(input key_info_t k);
        case (k.cls)
            KC_OCT_DN:  return 4'd12;
            KC_OCT_UP:  return 4'd13;
            KC_ADSR_DN: return 4'd14;
            KC_ADSR_UP: return 4'd15;
            default:    return k.idx;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_lut.sv
// Combinational scancode classifier.
//   scancode : set-2 scancode byte (input, 8 bits)
//   key_info : {class, index}; index is the note 0..11 or selector 0..4,
//              class KC_NONE for any unmapped byte (output)
module ps2_key_lut
    import ps2_note_pkg::*;
(
    input  logic [7:0] scancode,
    output key_info_t  key_info
);

    always_comb begin
        // NOTE: a default before the case keeps this block free of inferred
        // latches; every unlisted byte falls through to KC_NONE.
        key_info = '{cls: KC_NONE, idx: 4'd0};
        case (scancode)
            SC_A: key_info = '{cls: KC_NOTE, idx: 4'd0};
            SC_W: key_info = '{cls: KC_NOTE, idx: 4'd1};
            SC_S: key_info = '{cls: KC_NOTE, idx: 4'd2};
            SC_E: key_info = '{cls: KC_NOTE, idx: 4'd3};
            SC_D: key_info = '{cls: KC_NOTE, idx: 4'd4};
            SC_F: key_info = '{cls: KC_NOTE, idx: 4'd5};
            SC_T: key_info = '{cls: KC_NOTE, idx: 4'd6};
            SC_G: key_info = '{cls: KC_NOTE, idx: 4'd7};
            SC_Y: key_info = '{cls: KC_NOTE, idx: 4'd8};
            SC_H: key_info = '{cls: KC_NOTE, idx: 4'd9};
            SC_U: key_info = '{cls: KC_NOTE, idx: 4'd10};
            SC_J: key_info = '{cls: KC_NOTE, idx: 4'd11};
            SC_Z: key_info = '{cls: KC_OCT_DN,  idx: 4'd0};
            SC_X: key_info = '{cls: KC_OCT_UP,  idx: 4'd0};
            SC_C: key_info = '{cls: KC_ADSR_DN, idx: 4'd0};
            SC_V: key_info = '{cls: KC_ADSR_UP, idx: 4'd0};
            SC_1: key_info = '{cls: KC_SEL, idx: 4'd0};
            SC_2: key_info = '{cls: KC_SEL, idx: 4'd1};
            SC_3: key_info = '{cls: KC_SEL, idx: 4'd2};
            SC_4: key_info = '{cls: KC_SEL, idx: 4'd3};
            SC_5: key_info = '{cls: KC_SEL, idx: 4'd4};
            default: ;
        endcase
    end

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scancode to keyboard-synth control decoder.
// Monophonic, last-pressed priority, typematic repeats suppressed.
//   iClock, iReset        : clock, synchronous active-high reset
//   iByte, iByteValid     : scancode byte and its one-cycle strobe
//   oNote, oNoteIn        : current note index 0..11 and note-held level
//   oOctavePlusPlus/MinusMinus, oADSRPlusPlus/MinusMinus : 1-cycle pulses
//   oADSRSelector         : selected envelope stage 0..4
// All outputs update on the clock edge that samples iByteValid.
module ps2_note_decoder
    import ps2_note_pkg::*;
#(
    parameter int RETRIG_GAP = 1  // cycles oNoteIn stays low on retrigger, >= 1
)
(
    input  logic       iClock,
    input  logic       iReset,
    input  logic [7:0] iByte,
    input  logic       iByteValid,
    output logic [3:0] oNote,
    output logic       oNoteIn,
    output logic       oOctavePlusPlus,
    output logic       oOctaveMinusMinus,
    output logic       oADSRPlusPlus,
    output logic       oADSRMinusMinus,
    output logic [2:0] oADSRSelector
);

    localparam int               GAP_W    = $clog2(RETRIG_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RETRIG_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    state_t           state, state_next;
    logic             make_evt, break_evt;
    key_info_t        key_info;
    logic [3:0]       key_bit;
    logic             tracked, was_held, gap_busy;
    logic [15:0]      held;
    logic [GAP_W-1:0] gap_cnt;

    ps2_key_lut u_lut (
        .scancode (iByte),
        .key_info (key_info)
    );

    assign key_bit  = held_bit(key_info);
    assign tracked  = key_info.cls inside {KC_NOTE, KC_OCT_DN, KC_OCT_UP,
                                           KC_ADSR_DN, KC_ADSR_UP};
    assign was_held = held[key_bit];
    assign gap_busy = (gap_cnt != '0);

    // Byte FSM: state register
    always_ff @(posedge iClock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (iReset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Byte FSM: next state and make/break event decode
    always_comb begin
        state_next = state;
        make_evt   = 1'b0;
        break_evt  = 1'b0;
        if (iByteValid) begin
            case (state)
                ST_IDLE: begin
                    if (iByte == SC_E0)      state_next = ST_EXT;
                    else if (iByte == SC_F0) state_next = ST_BRK;
                    else                     make_evt   = 1'b1;
                end
                ST_BRK: begin
                    break_evt  = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_EXT:  state_next = (iByte == SC_F0) ? ST_EXT_BRK : ST_IDLE;
                default: state_next = ST_IDLE;  // ST_EXT_BRK: byte ignored
            endcase
        end
    end

    // Held bitmap, note/gap tracking and control outputs
    always_ff @(posedge iClock) begin
        if (iReset) begin
            held              <= '0;
            gap_cnt           <= '0;
            oNote             <= '0;
            oNoteIn           <= 1'b0;
            oOctavePlusPlus   <= 1'b0;
            oOctaveMinusMinus <= 1'b0;
            oADSRPlusPlus     <= 1'b0;
            oADSRMinusMinus   <= 1'b0;
            oADSRSelector     <= '0;
        end else begin
            oOctavePlusPlus   <= 1'b0;
            oOctaveMinusMinus <= 1'b0;
            oADSRPlusPlus     <= 1'b0;
            oADSRMinusMinus   <= 1'b0;

            // Gap countdown sits first: a byte action below that touches
            // oNoteIn or gap_cnt overrides the reassertion in the same cycle.
            if (gap_busy) begin
                gap_cnt <= gap_cnt - GAP_ONE;
                if (gap_cnt == GAP_ONE) oNoteIn <= 1'b1;
            end

            if (tracked && make_evt)  held[key_bit] <= 1'b1;
            if (tracked && break_evt) held[key_bit] <= 1'b0;

            if (make_evt) begin
                case (key_info.cls)
                    KC_NOTE: begin
                        if (!was_held) begin
                            oNote <= key_info.idx;
                            // A pending gap counts as sounding, so a new key
                            // during the gap reloads it rather than cutting it.
                            if (oNoteIn || gap_busy) begin
                                oNoteIn <= 1'b0;
                                gap_cnt <= GAP_LOAD;
                            end else begin
                                oNoteIn <= 1'b1;
                            end
                        end
                    end
                    KC_OCT_DN:  if (!was_held) oOctaveMinusMinus <= 1'b1;
                    KC_OCT_UP:  if (!was_held) oOctavePlusPlus   <= 1'b1;
                    KC_ADSR_DN: if (!was_held) oADSRMinusMinus   <= 1'b1;
                    KC_ADSR_UP: if (!was_held) oADSRPlusPlus     <= 1'b1;
                    KC_SEL:     oADSRSelector <= key_info.idx[2:0];
                    default: ;
                endcase
            end

            // Releasing the sounding note silences it and cancels any gap;
            // releasing any other note only clears its held bit.
            if (break_evt && key_info.cls == KC_NOTE && key_info.idx == oNote) begin
                oNoteIn <= 1'b0;
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed self-checking bench for ps2_note_decoder (RETRIG_GAP = 1).
module tb_ps2_note_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [3:0] note;
    logic       note_in;
    logic       oct_up, oct_dn, adsr_up, adsr_dn;
    logic [2:0] sel;

    int total = 0;
    int bad = 0;

    // Negedge monitors: pulse-cycle counts and oNoteIn edge counts
    int cnt_oct_up = 0, cnt_oct_dn = 0, cnt_adsr_up = 0, cnt_adsr_dn = 0;
    int cnt_multi = 0, cnt_rise = 0, cnt_fall = 0;
    logic prev_note_in = 1'b0;

    ps2_note_decoder #(.RETRIG_GAP(1)) dut (
        .iClock            (clk),
        .iReset            (rst),
        .iByte             (byte_in),
        .iByteValid        (byte_valid),
        .oNote             (note),
        .oNoteIn           (note_in),
        .oOctavePlusPlus   (oct_up),
        .oOctaveMinusMinus (oct_dn),
        .oADSRPlusPlus     (adsr_up),
        .oADSRMinusMinus   (adsr_dn),
        .oADSRSelector     (sel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (oct_up)  cnt_oct_up  <= cnt_oct_up + 1;
        if (oct_dn)  cnt_oct_dn  <= cnt_oct_dn + 1;
        if (adsr_up) cnt_adsr_up <= cnt_adsr_up + 1;
        if (adsr_dn) cnt_adsr_dn <= cnt_adsr_dn + 1;
        if ((int'(oct_up) + int'(oct_dn) + int'(adsr_up) + int'(adsr_dn)) > 1)
            cnt_multi <= cnt_multi + 1;
        if (note_in && !prev_note_in) cnt_rise <= cnt_rise + 1;
        if (!note_in && prev_note_in) cnt_fall <= cnt_fall + 1;
        prev_note_in <= note_in;
    end

    // Strobe one byte; returns on the negedge just after the sampling edge,
    // where the resulting outputs are already visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({note, note_in, oct_up, oct_dn, adsr_up, adsr_dn, sel} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got note=%0d in=%b pulses=%b%b%b%b sel=%0d want all 0",
                     note, note_in, oct_up, oct_dn, adsr_up, adsr_dn, sel);
        end
    endtask

    task automatic test_basic_note();
        do_reset();
        send_byte(8'h1C);
        total++;
        if (note_in !== 1'b1 || note !== 4'd0) begin
            bad++;
            $display("FAIL basic_make: got note=%0d in=%b want note=0 in=1", note, note_in);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++;
        if (note_in !== 1'b0 || note !== 4'd0) begin
            bad++;
            $display("FAIL basic_break: got note=%0d in=%b want note=0 in=0", note, note_in);
        end
    endtask

    task automatic test_typematic();
        int r0, f0;
        do_reset();
        r0 = cnt_rise;
        f0 = cnt_fall;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h1C);
            total++;
            if (note_in !== 1'b1) begin
                bad++;
                $display("FAIL typematic_hold[%0d]: got in=%b want 1", i, note_in);
            end
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        idle(1);
        total++;
        if (cnt_rise - r0 !== 1 || cnt_fall - f0 !== 1 || note_in !== 1'b0) begin
            bad++;
            $display("FAIL typematic_edges: got rises=%0d falls=%0d in=%b want 1 1 0",
                     cnt_rise - r0, cnt_fall - f0, note_in);
        end
    endtask

    task automatic test_retrigger();
        int r0, f0;
        do_reset();
        send_byte(8'h1C);
        #1;
        r0 = cnt_rise;
        f0 = cnt_fall;
        send_byte(8'h24);  // E key -> note 3
        total++;
        if (note !== 4'd3 || note_in !== 1'b0) begin
            bad++;
            $display("FAIL retrig_gap: got note=%0d in=%b want note=3 in=0", note, note_in);
        end
        @(negedge clk);
        total++;
        if (note_in !== 1'b1) begin
            bad++;
            $display("FAIL retrig_reassert: got in=%b want 1", note_in);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++;
        if (note !== 4'd3 || note_in !== 1'b1) begin
            bad++;
            $display("FAIL retrig_old_break: got note=%0d in=%b want note=3 in=1", note, note_in);
        end
        send_byte(8'hF0);
        send_byte(8'h24);
        total++;
        if (note !== 4'd3 || note_in !== 1'b0) begin
            bad++;
            $display("FAIL retrig_cur_break: got note=%0d in=%b want note=3 in=0", note, note_in);
        end
        idle(1);
        total++;
        if (cnt_rise - r0 !== 1 || cnt_fall - f0 !== 2) begin
            bad++;
            $display("FAIL retrig_edges: got rises=%0d falls=%0d want 1 2",
                     cnt_rise - r0, cnt_fall - f0);
        end
    endtask

    task automatic test_controls();
        int ou, od, au, ad;
        do_reset();
        ou = cnt_oct_up; od = cnt_oct_dn; au = cnt_adsr_up; ad = cnt_adsr_dn;
        send_byte(8'h22);
        total++;
        if (oct_up !== 1'b1) begin
            bad++;
            $display("FAIL oct_up_latency: got %b want 1", oct_up);
        end
        send_byte(8'h22);
        send_byte(8'h22);
        send_byte(8'hF0);
        send_byte(8'h22);
        send_byte(8'h22);
        idle(2);
        total++;
        if (cnt_oct_up - ou !== 2 || cnt_adsr_up - au !== 0) begin
            bad++;
            $display("FAIL oct_up_count: got oct_up=%0d adsr_up=%0d cycles want 2 0",
                     cnt_oct_up - ou, cnt_adsr_up - au);
        end
        foreach (byte_seq_v[i]) send_byte(byte_seq_v[i]);
        idle(2);
        total++;
        if (cnt_adsr_up - au !== 2 || cnt_oct_up - ou !== 2) begin
            bad++;
            $display("FAIL adsr_up_count: got adsr_up=%0d oct_up=%0d cycles want 2 2",
                     cnt_adsr_up - au, cnt_oct_up - ou);
        end
        send_byte(8'h1A);
        send_byte(8'h1A);
        send_byte(8'h21);
        idle(2);
        total++;
        if (cnt_oct_dn - od !== 1 || cnt_adsr_dn - ad !== 1 || cnt_multi !== 0) begin
            bad++;
            $display("FAIL down_pulses: got oct_dn=%0d adsr_dn=%0d multi=%0d want 1 1 0",
                     cnt_oct_dn - od, cnt_adsr_dn - ad, cnt_multi);
        end
    endtask

    logic [7:0] byte_seq_v [6] = '{8'h2A, 8'h2A, 8'h2A, 8'hF0, 8'h2A, 8'h2A};

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h1C);
        total++;
        if (note_in !== 1'b0 || note !== 4'd0) begin
            bad++;
            $display("FAIL ext_make_ignored: got note=%0d in=%b want note=0 in=0", note, note_in);
        end
        send_byte(8'h1D);  // plain make of W after the ignored prefix
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1D);
        total++;
        if (note_in !== 1'b1 || note !== 4'd1) begin
            bad++;
            $display("FAIL ext_break_ignored: got note=%0d in=%b want note=1 in=1", note, note_in);
        end
        send_byte(8'h25);
        total++;
        if (sel !== 3'd3 || note_in !== 1'b1) begin
            bad++;
            $display("FAIL ext_then_sel: got sel=%0d in=%b want sel=3 in=1", sel, note_in);
        end
    endtask

    task automatic test_selector_unmapped();
        logic [7:0] keys [3]  = '{8'h16, 8'h2E, 8'h1E};
        logic [2:0] wants [3] = '{3'd0, 3'd4, 3'd1};
        do_reset();
        send_byte(8'h3B);  // J -> note 11
        for (int i = 0; i < 3; i++) begin
            send_byte(keys[i]);
            total++;
            if (sel !== wants[i]) begin
                bad++;
                $display("FAIL selector[%0d]: got %0d want %0d", i, sel, wants[i]);
            end
        end
        send_byte(8'h55);
        send_byte(8'hF0);
        send_byte(8'h55);
        total++;
        if (note !== 4'd11 || note_in !== 1'b1 || sel !== 3'd1) begin
            bad++;
            $display("FAIL unmapped: got note=%0d in=%b sel=%0d want 11 1 1", note, note_in, sel);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'hF0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h1C);
        total++;
        if (note_in !== 1'b1 || note !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid_prefix: got note=%0d in=%b want note=0 in=1", note, note_in);
        end
    endtask

    initial begin
        test_reset();
        test_basic_note();
        test_typematic();
        test_retrigger();
        test_controls();
        test_extended();
        test_selector_unmapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
